// File: rtl/serv_rf_ram_pkg.sv
// Shared definitions for the SERV register-file RAM interface: read FSM
// encoding, RAM geometry derivation and RAM address formation.
package serv_rf_ram_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH0 = 3'd1,
        FETCH1 = 3'd2,
        READY  = 3'd3,
        STREAM = 3'd4
    } rd_state_e;

    function automatic bit width_ok(input int width);
        return (width == 4) || (width == 8) || (width == 16) || (width == 32);
    endfunction

    // RAM words per 32-bit register
    function automatic int wpr_of(input int width);
        return 32 / width;
    endfunction

    function automatic int aw_of(input int width);
        return 6 + $clog2(32 / width);
    endfunction

    // {reg, word_index} with a word-index field of iw bits (iw may be 0)
    function automatic logic [31:0] ram_addr(input logic [5:0] rreg,
                                             input logic [4:0] idx,
                                             input int iw);
        return ({26'd0, rreg} << iw) | {27'd0, idx};
    endfunction

endpackage

// File: rtl/serv_rf_ram_wbuf.sv
// Write path: gathers the two serial write streams into RAM words and
// issues the port0 word, then the port1 word, one RAM write per cycle.
module serv_rf_ram_wbuf
    import serv_rf_ram_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int AW = aw_of(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [5:0]       i_wreg0,
    input  logic [5:0]       i_wreg1,
    input  logic             i_wen0,
    input  logic             i_wen1,
    input  logic             i_wdata0,
    input  logic             i_wdata1,
    output logic [AW-1:0]    o_waddr,
    output logic [WIDTH-1:0] o_wdata,
    output logic             o_wen
);

    localparam int IW = AW - 6;
    localparam int LW = $clog2(WIDTH);
    localparam logic [4:0] POS_MASK = 5'(WIDTH - 1);

    logic [4:0]       wcnt;
    logic [WIDTH-1:0] gat0, gat1, word0, word1;
    logic [WIDTH-1:0] gat0_nxt, gat1_nxt;
    logic [5:0]       wreg0_q, wreg1_q;
    logic             wen0_q, wen1_q;
    logic [4:0]       idx_q;
    logic             slot0, slot1;
    logic             active, boundary;
    logic [31:0]      waddr_w;

    assign active   = i_wen0 | i_wen1;
    assign boundary = active && ((wcnt & POS_MASK) == POS_MASK);
    assign gat0_nxt = {i_wdata0, gat0[WIDTH-1:1]};
    assign gat1_nxt = {i_wdata1, gat1[WIDTH-1:1]};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wcnt    <= '0;
            gat0    <= '0;
            gat1    <= '0;
            word0   <= '0;
            word1   <= '0;
            wreg0_q <= '0;
            wreg1_q <= '0;
            wen0_q  <= 1'b0;
            wen1_q  <= 1'b0;
            idx_q   <= '0;
            slot0   <= 1'b0;
            slot1   <= 1'b0;
        end else begin
            if (active) begin
                wcnt <= wcnt + 5'd1;
                gat0 <= gat0_nxt;
                gat1 <= gat1_nxt;
            end
            // The word boundary includes the bit arriving this cycle
            if (boundary) begin
                word0   <= gat0_nxt;
                word1   <= gat1_nxt;
                wreg0_q <= i_wreg0;
                wreg1_q <= i_wreg1;
                wen0_q  <= i_wen0;
                wen1_q  <= i_wen1;
                idx_q   <= wcnt >> LW;
            end
            slot0 <= boundary;
            slot1 <= slot0;
        end
    end

    always_comb begin
        o_wen   = 1'b0;
        waddr_w = '0;
        o_wdata = '0;
        if (slot0 && wen0_q) begin
            o_wen   = 1'b1;
            waddr_w = ram_addr(wreg0_q, idx_q, IW);
            o_wdata = word0;
        end else if (slot1 && wen1_q) begin
            o_wen   = 1'b1;
            waddr_w = ram_addr(wreg1_q, idx_q, IW);
            o_wdata = word1;
        end
    end

    assign o_waddr = waddr_w[AW-1:0];

endmodule

// File: rtl/serv_rf_ram_if.sv
// Bridges SERV's bit-serial register file ports onto a WIDTH-bit RAM.
// Handshakes: i_rreq is a one-cycle request taken only in IDLE; o_ready pulses once and bit 0 streams the next cycle. o_ren is a read strobe whose data is on i_rdata one cycle later.
module serv_rf_ram_if
    import serv_rf_ram_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int AW = aw_of(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_rreq,
    output logic             o_ready,
    input  logic [5:0]       i_rreg0,
    input  logic [5:0]       i_rreg1,
    output logic             o_rdata0,
    output logic             o_rdata1,
    input  logic [5:0]       i_wreg0,
    input  logic [5:0]       i_wreg1,
    input  logic             i_wen0,
    input  logic             i_wen1,
    input  logic             i_wdata0,
    input  logic             i_wdata1,
    output logic [AW-1:0]    o_raddr,
    output logic             o_ren,
    input  logic [WIDTH-1:0] i_rdata,
    output logic [AW-1:0]    o_waddr,
    output logic [WIDTH-1:0] o_wdata,
    output logic             o_wen
);

    localparam int WPR = wpr_of(WIDTH);
    localparam int IW  = AW - 6;
    localparam int LW  = $clog2(WIDTH);
    localparam logic [4:0] POS_MASK = 5'(WIDTH - 1);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("serv_rf_ram_if: WIDTH must be 4, 8, 16 or 32");
    end

    rd_state_e        state, state_nxt;
    logic [4:0]       bit_cnt, pos, word_k;
    logic [5:0]       rreg0, rreg1;
    logic [WIDTH-1:0] buf0, buf1, sr0, sr1;
    logic             last_word;
    logic [31:0]      raddr_w;

    assign pos       = bit_cnt & POS_MASK;
    assign word_k    = bit_cnt >> LW;
    assign last_word = (word_k == 5'(WPR - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (i_rreq) state_nxt = FETCH0;
            FETCH0:  state_nxt = FETCH1;
            FETCH1:  state_nxt = READY;
            READY:   state_nxt = STREAM;
            STREAM:  if (bit_cnt == 5'd31) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_ready = 1'b0;
        o_ren   = 1'b0;
        raddr_w = '0;
        unique case (state)
            FETCH0: begin
                o_ren   = 1'b1;
                raddr_w = ram_addr(rreg0, 5'd0, IW);
            end
            FETCH1: begin
                o_ren   = 1'b1;
                raddr_w = ram_addr(rreg1, 5'd0, IW);
            end
            READY: o_ready = 1'b1;
            STREAM: begin
                // Fetch the next word of each register early in the current word
                if (!last_word && pos == 5'd0) begin
                    o_ren   = 1'b1;
                    raddr_w = ram_addr(rreg0, word_k + 5'd1, IW);
                end else if (!last_word && pos == 5'd1) begin
                    o_ren   = 1'b1;
                    raddr_w = ram_addr(rreg1, word_k + 5'd1, IW);
                end
            end
            default: ;
        endcase
    end

    assign o_raddr  = raddr_w[AW-1:0];
    assign o_rdata0 = (state == STREAM) & sr0[0];
    assign o_rdata1 = (state == STREAM) & sr1[0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rreg0   <= '0;
            rreg1   <= '0;
            buf0    <= '0;
            buf1    <= '0;
            sr0     <= '0;
            sr1     <= '0;
            bit_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: if (i_rreq) begin
                    rreg0 <= i_rreg0;
                    rreg1 <= i_rreg1;
                end
                FETCH1: buf0 <= i_rdata;
                READY: begin
                    sr0     <= buf0;
                    sr1     <= i_rdata;
                    bit_cnt <= '0;
                end
                STREAM: begin
                    bit_cnt <= bit_cnt + 5'd1;
                    if (pos == POS_MASK && !last_word) begin
                        sr0 <= buf0;
                        sr1 <= buf1;
                    end else begin
                        sr0 <= sr0 >> 1;
                        sr1 <= sr1 >> 1;
                    end
                    if (!last_word && pos == 5'd1) buf0 <= i_rdata;
                    if (!last_word && pos == 5'd2) buf1 <= i_rdata;
                end
                default: ;
            endcase
        end
    end

    serv_rf_ram_wbuf #(.WIDTH(WIDTH)) u_wbuf (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_wreg0  (i_wreg0),
        .i_wreg1  (i_wreg1),
        .i_wen0   (i_wen0),
        .i_wen1   (i_wen1),
        .i_wdata0 (i_wdata0),
        .i_wdata1 (i_wdata1),
        .o_waddr  (o_waddr),
        .o_wdata  (o_wdata),
        .o_wen    (o_wen)
    );

endmodule

// File: tb/tb_serv_rf_ram_if.sv
// Directed bench for serv_rf_ram_if: a WIDTH=8 instance for read, write and
// reset scenarios plus a WIDTH=32 instance for the single-word read case.
module tb_serv_rf_ram_if;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       a_rreq = 1'b0;
    logic [5:0] a_rreg0 = '0, a_rreg1 = '0;
    logic       a_ready, a_rd0, a_rd1, a_ren, a_wen;
    logic [7:0] a_raddr, a_waddr, a_wdata;
    logic [7:0] a_rdata = '0;
    logic [5:0] wreg0 = '0, wreg1 = '0;
    logic       wen0 = 1'b0, wen1 = 1'b0, wd0 = 1'b0, wd1 = 1'b0;

    // WIDTH=32 instance
    logic        b_rreq = 1'b0;
    logic [5:0]  b_rreg0 = '0, b_rreg1 = '0;
    logic        b_ready, b_rd0, b_rd1, b_ren, b_wen;
    logic [5:0]  b_raddr, b_waddr;
    logic [31:0] b_wdata;
    logic [31:0] b_rdata = '0;

    logic [7:0]  mem8  [256];
    logic [31:0] mem32 [64];
    logic [15:0] wr_q  [$];
    logic [15:0] exp_q [$];

    int checks = 0;
    int errors = 0;

    serv_rf_ram_if #(.WIDTH(8)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_rreq(a_rreq), .o_ready(a_ready),
        .i_rreg0(a_rreg0), .i_rreg1(a_rreg1), .o_rdata0(a_rd0), .o_rdata1(a_rd1),
        .i_wreg0(wreg0), .i_wreg1(wreg1), .i_wen0(wen0), .i_wen1(wen1),
        .i_wdata0(wd0), .i_wdata1(wd1), .o_raddr(a_raddr), .o_ren(a_ren),
        .i_rdata(a_rdata), .o_waddr(a_waddr), .o_wdata(a_wdata), .o_wen(a_wen)
    );

    serv_rf_ram_if #(.WIDTH(32)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_rreq(b_rreq), .o_ready(b_ready),
        .i_rreg0(b_rreg0), .i_rreg1(b_rreg1), .o_rdata0(b_rd0), .o_rdata1(b_rd1),
        .i_wreg0(6'd0), .i_wreg1(6'd0), .i_wen0(1'b0), .i_wen1(1'b0),
        .i_wdata0(1'b0), .i_wdata1(1'b0), .o_raddr(b_raddr), .o_ren(b_ren),
        .i_rdata(b_rdata), .o_waddr(b_waddr), .o_wdata(b_wdata), .o_wen(b_wen)
    );

    // RAM models: read data one cycle after the strobe
    always @(posedge clk) if (a_ren) a_rdata <= mem8[a_raddr];
    always @(posedge clk) if (b_ren) b_rdata <= mem32[b_raddr];

    always @(negedge clk) if (a_wen) wr_q.push_back({a_waddr, a_wdata});

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cycle 0 issues the request; dup_c re-requests with swapped registers.
    task automatic run_read(input bit inst, input logic [5:0] r0, input logic [5:0] r1,
                            input logic [31:0] v0, input logic [31:0] v1, input int dup_c);
        int w, wpr, nreads;
        w      = inst ? 32 : 8;
        wpr    = 32 / w;
        nreads = 0;
        for (int c = 0; c <= 38; c++) begin
            logic ready, ren, d0, d1, e_ren, e_d0, e_d1, stream;
            logic [7:0] addr;
            int n, ea;
            @(negedge clk);
            ready = inst ? b_ready : a_ready;
            ren   = inst ? b_ren   : a_ren;
            d0    = inst ? b_rd0   : a_rd0;
            d1    = inst ? b_rd1   : a_rd1;
            addr  = inst ? 8'(b_raddr) : a_raddr;
            n      = c - 4;
            stream = (c >= 4) && (c <= 35);
            e_d0 = 1'b0;
            e_d1 = 1'b0;
            ea   = 0;
            if (stream) begin
                e_d0 = v0[n];
                e_d1 = v1[n];
            end
            e_ren = (c == 1) || (c == 2) || (stream && (n % w) < 2 && (n / w) < wpr - 1);
            if (c == 1)      ea = r0 * wpr;
            else if (c == 2) ea = r1 * wpr;
            else if (stream) ea = (((n % w) == 0) ? r0 : r1) * wpr + n / w + 1;
            check($sformatf("rd w%0d c%0d ready/ren/bit0/bit1", w, c),
                  {ready, ren, d0, d1}, {(c == 3), e_ren, e_d0, e_d1});
            if (e_ren) check($sformatf("rd w%0d c%0d raddr", w, c), addr, 8'(ea));
            if (ren) nreads++;
            if (inst) begin
                b_rreq  = (c == 0) || (c == dup_c);
                b_rreg0 = (c == 0) ? r0 : r1;
                b_rreg1 = (c == 0) ? r1 : r0;
            end else begin
                a_rreq  = (c == 0) || (c == dup_c);
                a_rreg0 = (c == 0) ? r0 : r1;
                a_rreg1 = (c == 0) ? r1 : r0;
            end
        end
        check($sformatf("rd w%0d read count", w), nreads, 2 * wpr);
    endtask

    task automatic run_write(input logic [5:0] r0, input logic [5:0] r1, input logic e0,
                             input logic e1, input logic [31:0] d0, input logic [31:0] d1);
        int base;
        base = wr_q.size();
        for (int k = 0; k < 4; k++) begin
            if (e0) exp_q.push_back({8'(r0 * 4 + k), d0[8*k +: 8]});
            if (e1) exp_q.push_back({8'(r1 * 4 + k), d1[8*k +: 8]});
        end
        for (int c = 0; c <= 35; c++) begin
            @(negedge clk);
            wen0  = (c < 32) && e0;
            wen1  = (c < 32) && e1;
            wd0   = (c < 32) ? d0[c] : 1'b0;
            wd1   = (c < 32) ? d1[c] : 1'b0;
            wreg0 = r0;
            wreg1 = r1;
        end
        @(negedge clk);
        check($sformatf("wr reg%0d/%0d count", r0, r1), wr_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [15:0] obs;
            obs = (base + i < wr_q.size()) ? wr_q[base + i] : 16'hxxxx;
            check($sformatf("wr reg%0d/%0d entry %0d", r0, r1, i), obs, exp_q[i]);
        end
        exp_q.delete();
    endtask

    initial begin
        logic [31:0] v3, v5;
        logic [7:0]  cdata;
        int          base;
        v3    = 32'hDEADBEEF;
        v5    = 32'h12345678;
        cdata = 8'hC3;
        for (int i = 0; i < 256; i++) mem8[i] = 8'(i * 7 + 3);
        for (int i = 0; i < 64; i++) mem32[i] = {4{8'(i * 11 + 1)}};
        for (int k = 0; k < 4; k++) begin
            mem8[12 + k] = v3[8*k +: 8];
            mem8[20 + k] = v5[8*k +: 8];
        end
        mem32[3] = v3;
        mem32[5] = v5;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset outputs w8", {a_ready, a_ren, a_wen, a_rd0, a_rd1, a_raddr, a_waddr, a_wdata}, '0);
        check("reset outputs w32", {b_ready, b_ren, b_wen, b_rd0, b_rd1, b_raddr, b_waddr, b_wdata}, '0);
        rst = 1'b0;
        @(negedge clk);

        // Read reg3/reg5 with an ignored second request mid-stream
        run_read(1'b0, 6'd3, 6'd5, v3, v5, 15);

        // Dual-port and single-port writes
        run_write(6'd7, 6'd33, 1'b1, 1'b1, 32'hA5A5A5A5, 32'h0F0F0F0F);
        run_write(6'd9, 6'd40, 1'b1, 1'b0, 32'h3C3C3C3C, 32'hFFFFFFFF);

        // Reset at stream cycle 10, between the port0 and port1 writes
        base = wr_q.size();
        for (int c = 0; c <= 13; c++) begin
            @(negedge clk);
            if (c == 3) check("rst-test ready", a_ready, 1'b1);
            if (c == 13) check("rst-test port0 write", {a_wen, a_waddr, a_wdata}, {1'b1, 8'd44, 8'hC3});
            a_rreq  = (c == 0);
            a_rreg0 = 6'd3;
            a_rreg1 = 6'd5;
            wen0    = (c >= 5) && (c <= 12);
            wen1    = (c >= 5) && (c <= 12);
            wd0     = ((c >= 5) && (c <= 12)) ? cdata[c - 5] : 1'b0;
            wd1     = 1'b1;
            wreg0   = 6'd11;
            wreg1   = 6'd12;
        end
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check("rst-test outputs at assert",
                 {a_ready, a_ren, a_wen, a_rd0, a_rd1, a_raddr, a_waddr, a_wdata}, '0);
        @(negedge clk);
        check("rst-test outputs held",
              {a_ready, a_ren, a_wen, a_rd0, a_rd1, a_raddr, a_waddr, a_wdata}, '0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst-test write count", wr_q.size() - base, 1);
        check("rst-test write entry", wr_q[base], {8'd44, 8'hC3});
        run_read(1'b0, 6'd5, 6'd3, v5, v3, -1);
        check("rst-test no late write", wr_q.size() - base, 1);

        // Single-word geometry: two fetches, no prefetch
        run_read(1'b1, 6'd3, 6'd5, v3, v5, 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
